// File: rtl/bad_apple_pkg.sv
// Shared frame geometry and frame-writer state encoding for the bad-apple
// video path; VGA_top takes its frame dimensions from here as well.
package bad_apple_pkg;

  localparam int FRAME_W     = 480;
  localparam int FRAME_H     = 360;
  localparam int WORD_W      = 16;
  localparam int FRAME_WORDS = FRAME_W * FRAME_H / WORD_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    PENDING = 2'd2
  } fbw_state_t;

endpackage

// File: rtl/bit_packer.sv
// Serial-to-parallel packer: shifts accepted bits in MSB-first and flags the
// cycle in which the incoming bit completes a word.
module bit_packer #(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              clear,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid
);

  localparam int CNT_W = $clog2(WORD_W);

  // Only WORD_W-1 bits need storing; the completing bit arrives live.
  logic [WORD_W-2:0] shift;
  logic [CNT_W-1:0]  bit_cnt;

  assign word_out   = {shift, bit_in};
  assign word_valid = bit_valid && (bit_cnt == CNT_W'(WORD_W - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else if (bit_valid) begin
      shift   <= word_out[WORD_W-2:0];
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/frame_bank_writer.sv
// Packs the serial video stream into RAM words, fills the back bank of a
// double-buffered frame memory and swaps banks on the next VGA vsync.
module frame_bank_writer #(
  parameter int FRAME_W     = bad_apple_pkg::FRAME_W,
  parameter int FRAME_H     = bad_apple_pkg::FRAME_H,
  parameter int WORD_W      = bad_apple_pkg::WORD_W,
  parameter int FRAME_WORDS = FRAME_W * FRAME_H / WORD_W,
  parameter int ADDR_W      = $clog2(FRAME_WORDS)
) (
  input  logic              CLK_40,
  input  logic              reset,
  input  logic              received_bit,
  input  logic              bit_valid,
  input  logic              video_data_ready,
  input  logic              vga_vsync_pulse,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              display_bank,
  output logic              frame_done,
  output logic              short_frame,
  output logic              overrun
);

  import bad_apple_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FRAME_WORDS - 1);

  fbw_state_t        state, state_nx;
  logic              vdr_prev;
  logic              rise;
  logic              accept, clear;
  logic              word_valid;
  logic [WORD_W-1:0] word_out;
  logic [ADDR_W-1:0] word_cnt, word_cnt_nx;
  logic              issue, swap, short_nx, overrun_nx;

  assign rise    = video_data_ready && !vdr_prev;
  assign wr_bank = ~display_bank;

  bit_packer #(
    .WORD_W(WORD_W)
  ) u_packer (
    .clk       (CLK_40),
    .reset     (reset),
    .bit_in    (received_bit),
    .bit_valid (accept),
    .clear     (clear),
    .word_out  (word_out),
    .word_valid(word_valid)
  );

  always_ff @(posedge CLK_40) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    word_cnt_nx = word_cnt;
    accept      = 1'b0;
    clear       = 1'b0;
    issue       = 1'b0;
    swap        = 1'b0;
    short_nx    = 1'b0;
    overrun_nx  = 1'b0;
    case (state)
      IDLE: begin
        word_cnt_nx = '0;
        if (rise) begin
          state_nx = FILL;
          accept   = bit_valid;
        end else begin
          clear = 1'b1;
        end
      end
      FILL: begin
        if (!video_data_ready) begin
          // A falling ready wins over a word-completing bit: nothing written.
          short_nx    = 1'b1;
          clear       = 1'b1;
          word_cnt_nx = '0;
          state_nx    = IDLE;
        end else begin
          accept = bit_valid;
          if (word_valid) begin
            issue = 1'b1;
            if (word_cnt == LAST_WORD) begin
              word_cnt_nx = '0;
              state_nx    = PENDING;
            end else begin
              word_cnt_nx = word_cnt + 1'b1;
            end
          end
        end
      end
      PENDING: begin
        clear      = 1'b1;
        overrun_nx = bit_valid;
        if (vga_vsync_pulse) begin
          swap     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: begin
        clear    = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end

  // Registered outputs: write port, bank select and status pulses.
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      vdr_prev     <= 1'b0;
      word_cnt     <= '0;
      display_bank <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      frame_done   <= 1'b0;
      short_frame  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      vdr_prev     <= video_data_ready;
      word_cnt     <= word_cnt_nx;
      display_bank <= display_bank ^ swap;
      wr_en        <= issue;
      frame_done   <= swap;
      short_frame  <= short_nx;
      overrun      <= overrun_nx;
      if (issue) begin
        wr_addr <= word_cnt;
        wr_data <= word_out;
      end
    end
  end

endmodule
